fruit_spawn_sched: RTL

- Schedules fruit launches for the three fruit slots in the game top.
- Issues one-cycle respawn pulses to the per-slot trajectory generators on a level-dependent frame gap, picking free slots round-robin.
- Tracks sliced versus missed fruit, keeps the missed count and raises the sticky game-over flag.
- Sits between the frame strobe/level logic and the three coordinate generators; replaces ad-hoc respawn timing in the game controller.

---
 rtl/fruit_spawn_sched.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/fruit_spawn_sched.sv
// Fruit launch scheduler for the three-slot game top.
// Issues round-robin respawn pulses on a level-dependent frame gap and counts missed fruit.
// Optional build macro SPAWN_BURST_EN: at level 3 a second free slot is launched on the
// cycle right after the first one.
module fruit_spawn_sched #(
  parameter int unsigned NSLOT      = 3,
  parameter int unsigned GAP_L0     = 60,
  parameter int unsigned GAP_STEP   = 15,
  parameter int unsigned MAX_MISS   = 5,
  parameter int unsigned SETTLE_MAX = 8
) (
  input  logic             ck,
  input  logic             res,
  input  logic             run,
  input  logic             frame,
  input  logic             pause,
  input  logic [1:0]       level,
  input  logic [NSLOT-1:0] active,
  input  logic [NSLOT-1:0] hit,
  output logic [NSLOT-1:0] rs,
  output logic [7:0]       missed,
  output logic             go
);

  localparam int unsigned PW = (NSLOT > 1) ? $clog2(NSLOT) : 1;

  typedef enum logic [2:0] {StIdle, StArm, StLaunch, StLaunch2, StSettle, StOver} state_e;

  state_e           state_q, state_d;
  logic [PW-1:0]    ptr_q, ptr_d, sel_q, sel_d;
  logic [7:0]       cnt_q, cnt_d, cnt_inc, stl_q, stl_d, gap, missed_q, missed_d;
  logic [8:0]       sum;
  logic [NSLOT-1:0] sliced_q, sliced_d, active_q, clr, miss_vec, rs_c;
  logic             frame_q, go_q, go_d, tick;
  logic [PW:0]      pick1;

  // First free slot at or after start, wrapping; MSB flags that one was found.
  function automatic logic [PW:0] pick_free(input logic [PW-1:0] start,
                                            input logic [NSLOT-1:0] avail);
    logic [PW:0] r;
    int unsigned idx;
    r = '0;
    for (int unsigned k = 0; k < NSLOT; k++) begin
      idx = (32'(start) + k) % NSLOT;
      if (!r[PW] && avail[PW'(idx)]) r = {1'b1, PW'(idx)};
    end
    return r;
  endfunction

  function automatic logic [PW-1:0] next_slot(input logic [PW-1:0] s);
    return PW'((32'(s) + 1) % NSLOT);
  endfunction

  assign tick     = frame & ~frame_q & ~pause;
  assign gap      = 8'(GAP_L0 - 32'(level) * GAP_STEP);
  assign cnt_inc  = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
  assign pick1    = pick_free(ptr_q, ~active);
  assign miss_vec = active_q & ~active & ~sliced_q & ~hit;

`ifdef SPAWN_BURST_EN
  logic [PW:0] pick2;
  // The slot just launched is still inactive, so mask it out of the second search.
  assign pick2 = pick_free(ptr_q, ~active & ~(NSLOT'(1) << sel_q));
`endif

  // Launch sequencing: next state, counters, pointer and respawn pulse.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stl_d   = stl_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    rs_c    = '0;
    clr     = '0;
    if (state_q == StOver || go_q) begin
      state_d = StOver;
    end else if (!run) begin
      state_d = StIdle;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          cnt_d   = '0;
          state_d = StArm;
        end
        StArm: begin
          if (cnt_q >= gap && (~active != '0)) begin
            state_d = StLaunch;
          end else if (tick && cnt_q < gap) begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        StLaunch: begin
          if (pick1[PW]) begin
            rs_c    = NSLOT'(1) << pick1[PW-1:0];
            clr     = rs_c;
            ptr_d   = next_slot(pick1[PW-1:0]);
            sel_d   = pick1[PW-1:0];
            cnt_d   = '0;
            stl_d   = '0;
            state_d = StSettle;
`ifdef SPAWN_BURST_EN
            if (level == 2'd3 && $countones(~active) >= 2) state_d = StLaunch2;
`endif
          end else begin
            // Slot taken between compare and launch: retry from ARM.
            state_d = StArm;
          end
        end
        StLaunch2: begin
`ifdef SPAWN_BURST_EN
          if (pick2[PW]) begin
            rs_c  = NSLOT'(1) << pick2[PW-1:0];
            clr   = rs_c;
            ptr_d = next_slot(pick2[PW-1:0]);
            sel_d = pick2[PW-1:0];
          end
          if (tick) cnt_d = cnt_inc;
`endif
          state_d = StSettle;
        end
        StSettle: begin
          if (tick) begin
            cnt_d = cnt_inc;
            stl_d = (stl_q == 8'hFF) ? stl_q : stl_q + 8'd1;
          end
          if (active[sel_q] || 32'(stl_q) >= SETTLE_MAX) state_d = StArm;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Slice/miss bookkeeping, independent of the launch FSM.
  always_comb begin
    sum      = {1'b0, missed_q} + 9'($countones(miss_vec));
    missed_d = sum[8] ? 8'hFF : sum[7:0];
    go_d     = go_q | (32'(missed_d) >= MAX_MISS);
    sliced_d = (sliced_q | (hit & active)) & ~clr;
  end

  // State registers with synchronous reset.
  always_ff @(posedge ck) begin
    if (res) begin
      state_q  <= StIdle;
      ptr_q    <= '0;
      sel_q    <= '0;
      cnt_q    <= '0;
      stl_q    <= '0;
      sliced_q <= '0;
      active_q <= '0;
      frame_q  <= 1'b0;
      missed_q <= '0;
      go_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      sel_q    <= sel_d;
      cnt_q    <= cnt_d;
      stl_q    <= stl_d;
      sliced_q <= sliced_d;
      active_q <= active;
      frame_q  <= frame;
      missed_q <= missed_d;
      go_q     <= go_d;
    end
  end

  assign rs     = rs_c;
  assign missed = missed_q;
  assign go     = go_q;

endmodule
